// File: rtl/spi_byte_engine.sv
// Byte-wide SPI master, mode 0, with selectable slow/fast sclk divider.
// One byte per accepted start; every output comes straight from a register.
module spi_byte_engine #(
  parameter int DIV_SLOW = 62,
  parameter int DIV_FAST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] txd,
  input  logic       speed,
  input  logic       cs_req,
  output logic [7:0] rxd,
  output logic       rdy,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [7:0] DIV_SLOW_L = 8'(DIV_SLOW);
  localparam logic [7:0] DIV_FAST_L = 8'(DIV_FAST);

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_reg, rx_next;
  logic [7:0] div_reg, div_next;
  logic [7:0] half_cnt_reg, half_cnt_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] rxd_reg, rxd_next;
  logic       rdy_reg, rdy_next;
  logic       busy_reg, busy_next;
  logic       sclk_reg, sclk_next;
  logic       mosi_reg, mosi_next;
  logic       cs_n_reg, cs_n_next;
  // A start that collides with a chip-select change is held here for one cycle.
  logic       pend_reg, pend_next;
  logic [7:0] pend_txd_reg, pend_txd_next;
  logic       pend_speed_reg, pend_speed_next;
  logic [7:0] use_txd;
  logic [7:0] use_div;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= 8'hFF;
      rx_reg         <= 8'h00;
      div_reg        <= 8'h00;
      half_cnt_reg   <= 8'h00;
      bit_cnt_reg    <= 3'd0;
      rxd_reg        <= 8'h00;
      rdy_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      sclk_reg       <= 1'b0;
      mosi_reg       <= 1'b1;
      cs_n_reg       <= 1'b1;
      pend_reg       <= 1'b0;
      pend_txd_reg   <= 8'hFF;
      pend_speed_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      rx_reg         <= rx_next;
      div_reg        <= div_next;
      half_cnt_reg   <= half_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      rxd_reg        <= rxd_next;
      rdy_reg        <= rdy_next;
      busy_reg       <= busy_next;
      sclk_reg       <= sclk_next;
      mosi_reg       <= mosi_next;
      cs_n_reg       <= cs_n_next;
      pend_reg       <= pend_next;
      pend_txd_reg   <= pend_txd_next;
      pend_speed_reg <= pend_speed_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    rx_next         = rx_reg;
    div_next        = div_reg;
    half_cnt_next   = half_cnt_reg;
    bit_cnt_next    = bit_cnt_reg;
    rxd_next        = rxd_reg;
    rdy_next        = 1'b0;
    busy_next       = busy_reg;
    sclk_next       = sclk_reg;
    mosi_next       = mosi_reg;
    cs_n_next       = cs_n_reg;
    pend_next       = pend_reg;
    pend_txd_next   = pend_txd_reg;
    pend_speed_next = pend_speed_reg;
    use_txd         = pend_reg ? pend_txd_reg : txd;
    use_div         = (pend_reg ? pend_speed_reg : speed) ? DIV_FAST_L : DIV_SLOW_L;

    case (state_reg)
      IDLE: begin
        sclk_next = 1'b0;
        mosi_next = 1'b1;
        if (cs_n_reg != ~cs_req) begin
          // Chip select moves first; a simultaneous start waits one cycle.
          cs_n_next = ~cs_req;
          if (start && !pend_reg) begin
            pend_next       = 1'b1;
            pend_txd_next   = txd;
            pend_speed_next = speed;
          end
        end else if (start || pend_reg) begin
          pend_next     = 1'b0;
          shift_next    = use_txd;
          div_next      = use_div;
          half_cnt_next = use_div;
          bit_cnt_next  = 3'd0;
          mosi_next     = use_txd[7];
          busy_next     = 1'b1;
          state_next    = LOW;
        end
      end
      LOW: begin
        if (half_cnt_reg == 8'd0) begin
          sclk_next     = 1'b1;
          rx_next       = {rx_reg[6:0], miso};
          half_cnt_next = div_reg;
          state_next    = HIGH;
        end else begin
          half_cnt_next = half_cnt_reg - 8'd1;
        end
      end
      HIGH: begin
        if (half_cnt_reg == 8'd0) begin
          sclk_next     = 1'b0;
          half_cnt_next = div_reg;
          if (bit_cnt_reg == 3'd7) begin
            rxd_next   = rx_reg;
            rdy_next   = 1'b1;
            mosi_next  = 1'b1;
            state_next = DONE;
          end else begin
            shift_next   = {shift_reg[6:0], 1'b1};
            mosi_next    = shift_reg[6];
            bit_cnt_next = bit_cnt_reg + 3'd1;
            state_next   = LOW;
          end
        end else begin
          half_cnt_next = half_cnt_reg - 8'd1;
        end
      end
      DONE: begin
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign rxd  = rxd_reg;
  assign rdy  = rdy_reg;
  assign busy = busy_reg;
  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign cs_n = cs_n_reg;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Scoreboard bench for spi_byte_engine: a driver queues expected bytes,
// a monitor acts as the SPI slave and checks every rdy pulse.
module tb_spi_byte_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] txd = 8'hFF;
  logic       speed = 1'b0;
  logic       cs_req = 1'b0;
  logic       miso = 1'b1;
  logic [7:0] rxd;
  logic       rdy, busy, sclk, mosi, cs_n;

  spi_byte_engine #(.DIV_SLOW(62), .DIV_FAST(1)) dut (
    .clk(clk), .rst(rst), .start(start), .txd(txd), .speed(speed),
    .cs_req(cs_req), .rxd(rxd), .rdy(rdy), .busy(busy), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         lat;
    int         acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slave_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Slave model + monitor: captures mosi on sclk rise, shifts miso after sclk fall.
  logic       prev_sclk = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] mosi_cap = 8'h00;
  logic [7:0] cur_byte;
  int nbits = 0;
  int sidx = 0;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      nbits = 0;
      sidx = 0;
      slave_q.delete();
      prev_sclk = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (sclk && !prev_sclk) begin
        mosi_cap = {mosi_cap[6:0], mosi};
        nbits++;
      end
      if (!sclk && prev_sclk) begin
        if (sidx == 7) begin
          sidx = 0;
          if (slave_q.size() != 0) void'(slave_q.pop_front());
        end else sidx++;
      end
      prev_sclk = sclk;
      if (rdy) begin
        check("rdy_single_cycle", prev_rdy, 0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL rdy_unexpected: got rdy=1 with rxd=%0h, expected no pending byte", rxd);
        end else begin
          e = exp_q.pop_front();
          check("rxd", rxd, e.rx);
          check("mosi_bits", mosi_cap, e.tx);
          check("sclk_pulses", nbits, 8);
          check("latency", cyc - e.acc, e.lat);
          check("busy_at_rdy", busy, 1);
        end
        nbits = 0;
      end
      prev_rdy = rdy;
    end
    if (slave_q.size() != 0) begin
      cur_byte = slave_q[0];
      miso = cur_byte[7 - sidx];
    end else miso = 1'b1;
  end

  task automatic send(input logic [7:0] t, input logic [7:0] r, input logic sp);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("send_wait_timeout", 1, 0);
    slave_q.push_back(r);
    txd = t;
    speed = sp;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    txd = 8'($urandom);
    speed = 1'($urandom);
    exp_q.push_back('{rx: r, tx: t, lat: 16 * ((sp ? 1 : 62) + 1), acc: cyc});
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain_timeout", 1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_sclk", sclk, 0);
    check("reset_mosi", mosi, 1);
    check("reset_cs_n", cs_n, 1);
    check("reset_rdy", rdy, 0);
    check("reset_busy", busy, 0);
    check("reset_rxd", rxd, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Known byte at fast speed
    send(8'hA5, 8'h3C, 1'b1);
    wait_drain();

    // Randomized back-to-back bytes at fast speed
    for (int i = 0; i < 20; i++) send(8'($urandom), 8'($urandom), 1'b1);
    wait_drain();

    // Slow dummy bytes, chip select idle
    for (int i = 0; i < 3; i++) send(8'hFF, 8'($urandom), 1'b0);
    wait_drain();
    check("cs_n_idle_slow", cs_n, 1);

    // Start while busy must be ignored
    send(8'h96, 8'h69, 1'b1);
    repeat (10) @(negedge clk);
    txd = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // cs_req change mid-byte lands only after the byte
    send(8'h5A, 8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    cs_req = 1'b1;
    repeat (10) @(negedge clk);
    check("cs_n_hold_busy", cs_n, 1);
    wait_drain();
    check("cs_n_hold_idle", cs_n, 1);
    @(negedge clk);
    check("cs_n_asserted", cs_n, 0);
    check("sclk_at_cs", sclk, 0);

    // Reset in the middle of a byte
    send(8'hC3, 8'h81, 1'b1);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 1);
    check("abort_busy", busy, 0);
    check("abort_rdy", rdy, 0);
    check("abort_rxd", rxd, 8'h00);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cs_req = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h51, 8'h2D, 1'b1);
    wait_drain();

    // Loader-style read stream
    send(8'hFF, 8'hFF, 1'b1);
    send(8'hFF, 8'hFF, 1'b1);
    send(8'hFF, 8'hFE, 1'b1);
    wait_drain();
    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

endmodule
